// File: rtl/cache_pkg.sv
// Shared types and width helpers for the direct-mapped write-through cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    function automatic int offset_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int lines, input int line_words);
        return addr_w - 2 - offset_w(line_words) - index_w(lines);
    endfunction

    // Fill counter keeps at least one bit even for single-word lines.
    function automatic int cnt_w(input int line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

endpackage

// File: rtl/cache_tagram.sv
// Valid bits and tags per line: combinational read, clocked write, valid bits cleared by reset.
module cache_tagram #(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] index,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    input  logic             wr_en,
    input  logic             wr_valid,
    input  logic [TAG_W-1:0] wr_tag
);

    logic [LINES-1:0] valid_reg;
    logic [TAG_W-1:0] tag_mem [LINES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
        end else if (wr_en) begin
            valid_reg[index] <= wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[index] <= wr_tag;
        end
    end

    assign rd_valid = valid_reg[index];
    assign rd_tag   = tag_mem[index];

endmodule

// File: rtl/cache.sv
// Direct-mapped, write-through, no-write-allocate cache with blocking line fill.
// Define CACHE_STATS_EN to add saturating read hit/miss counters.
module cache
    import cache_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = 32,
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              memread,
    input  logic              memwrite,
    output logic [WIDTH-1:0]  rdata,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int OFF_W   = offset_w(LINE_WORDS);
    localparam int IDX_W   = index_w(LINES);
    localparam int TAG_W   = tag_w(ADDR_W, LINES, LINE_WORDS);
    localparam int CNT_W   = cnt_w(LINE_WORDS);
    localparam int DIDX_W  = OFF_W + IDX_W;
    localparam int WADDR_W = ADDR_W - 2;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   fill_cnt_reg, fill_cnt_next;

    logic [WADDR_W-1:0] word_addr, fill_word;
    logic [IDX_W-1:0]   index;
    logic [TAG_W-1:0]   tag;
    logic               line_valid, hit;
    logic [TAG_W-1:0]   line_tag;
    logic               tag_we, tag_wr_valid;

    logic [WIDTH-1:0]   data_mem [LINES*LINE_WORDS];
    logic               data_we;
    logic [DIDX_W-1:0]  data_wr_idx;
    logic [WIDTH-1:0]   data_wr_val;

    assign word_addr = addr[ADDR_W-1:2];
    assign index     = word_addr[OFF_W +: IDX_W];
    assign tag       = word_addr[DIDX_W +: TAG_W];

    // Fill address walks the word offset of the held request's line.
    generate
        if (OFF_W > 0) begin : g_fill_word
            assign fill_word = {word_addr[WADDR_W-1:OFF_W], fill_cnt_reg};
        end else begin : g_fill_single
            assign fill_word = word_addr;
        end
    endgenerate

    cache_tagram #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tagram (
        .clk      (clk),
        .reset    (reset),
        .index    (index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .wr_en    (tag_we),
        .wr_valid (tag_wr_valid),
        .wr_tag   (tag)
    );

    assign hit = line_valid && (line_tag == tag);

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[data_wr_idx] <= data_wr_val;
        end
    end

    assign rdata = data_mem[word_addr[DIDX_W-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            fill_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            fill_cnt_reg <= fill_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        fill_cnt_next = fill_cnt_reg;
        stall         = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_addr      = addr;
        mem_wdata     = wdata;
        tag_we        = 1'b0;
        tag_wr_valid  = 1'b0;
        data_we       = 1'b0;
        data_wr_idx   = word_addr[DIDX_W-1:0];
        data_wr_val   = wdata;
        case (state_reg)
            IDLE: begin
                if (memwrite) begin
                    stall      = 1'b1;
                    state_next = WRITE;
                    data_we    = hit;
                end else if (memread && !hit) begin
                    // Invalidate up front so an abandoned fill never leaves a stale-valid line.
                    stall         = 1'b1;
                    state_next    = FILL;
                    fill_cnt_next = '0;
                    tag_we        = 1'b1;
                end
            end
            FILL: begin
                stall    = 1'b1;
                mem_read = 1'b1;
                mem_addr = {fill_word, 2'b00};
                if (mem_ready) begin
                    data_we       = 1'b1;
                    data_wr_idx   = fill_word[DIDX_W-1:0];
                    data_wr_val   = mem_rdata;
                    fill_cnt_next = fill_cnt_reg + 1'b1;
                    if (fill_cnt_reg == CNT_W'(LINE_WORDS - 1)) begin
                        tag_we       = 1'b1;
                        tag_wr_valid = 1'b1;
                        state_next   = IDLE;
                    end
                end
            end
            WRITE: begin
                mem_write = 1'b1;
                stall     = !mem_ready;
                if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef CACHE_STATS_EN
    // The held request re-presents right after a fill; it was already counted as a miss.
    logic refill_done_reg;
    logic read_access;

    assign read_access = (state_reg == IDLE) && memread && !memwrite;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refill_done_reg <= 1'b0;
            hit_count       <= '0;
            miss_count      <= '0;
        end else begin
            refill_done_reg <= (state_reg == FILL) && (state_next == IDLE);
            if (read_access && hit && !refill_done_reg && hit_count != '1) begin
                hit_count <= hit_count + 1'b1;
            end
            if (read_access && !hit && miss_count != '1) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache.sv
// Directed bench for the cache: reference memory with controllable ready, hand-computed expectations.
module tb_cache;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        memread;
    logic        memwrite;
    logic [31:0] rdata;
    logic        stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ready;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    logic [31:0] mem_model [0:1023];
    logic        ready_en;
    int          vectors;
    int          miscompares;

    cache dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .memread   (memread),
        .memwrite  (memwrite),
        .rdata     (rdata),
        .stall     (stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_ready (mem_ready)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ready = ready_en;
    assign mem_rdata = mem_model[mem_addr[11:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered and left just after a rising edge.
    task automatic load_hit(input logic [31:0] a, input logic [31:0] exp);
        addr = a; memread = 1'b1; memwrite = 1'b0;
        @(negedge clk);
        check("hit_stall", stall, 0);
        check("hit_no_memread", mem_read, 0);
        check("hit_rdata", rdata, exp);
        $display("load  %h hit  rdata=%h", a, rdata);
        step();
        memread = 1'b0;
    endtask

    task automatic load_miss(input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] base;
        base = {a[31:4], 4'h0};
        addr = a; memread = 1'b1; memwrite = 1'b0; ready_en = 1'b1;
        @(negedge clk);
        check("miss_stall", stall, 1);
        check("miss_idle_memread", mem_read, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("fill_memread", mem_read, 1);
            check("fill_addr", mem_addr, base + 32'(k * 4));
        end
        @(negedge clk);
        check("refill_stall", stall, 0);
        check("refill_rdata", rdata, exp);
        $display("load  %h miss rdata=%h", a, rdata);
        step();
        memread = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input int wait_cycles, input logic rd);
        addr = a; wdata = d; memwrite = 1'b1; memread = rd;
        ready_en = (wait_cycles == 0);
        @(negedge clk);
        check("st_idle_stall", stall, 1);
        check("st_idle_memwrite", mem_write, 0);
        for (int i = 0; i < wait_cycles; i++) begin
            @(negedge clk);
            check("st_wait_stall", stall, 1);
            check("st_wait_memwrite", mem_write, 1);
            check("st_wait_addr", mem_addr, a);
            check("st_wait_wdata", mem_wdata, d);
        end
        step();
        ready_en = 1'b1;
        @(negedge clk);
        check("st_done_stall", stall, 0);
        check("st_done_memwrite", mem_write, 1);
        check("st_done_memread", mem_read, 0);
        check("st_done_addr", mem_addr, a);
        check("st_done_wdata", mem_wdata, d);
        $display("store %h data=%h wait=%0d", a, d, wait_cycles);
        step();
        memwrite = 1'b0; memread = 1'b0;
        mem_model[a[11:2]] = d;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 1024; i++) begin
            mem_model[i] = 32'h1000_0000 | (32'(i) << 2);
        end
        reset = 1'b1; addr = '0; wdata = '0; memread = 1'b0; memwrite = 1'b0; ready_en = 1'b1;
        step();
        step();
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_memread", mem_read, 0);
        check("rst_memwrite", mem_write, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("idle_stall", stall, 0);
        check("idle_memread", mem_read, 0);
        step();

        load_miss(32'h40, 32'h1000_0040);
        load_hit(32'h48, 32'h1000_0048);
        store(32'h44, 32'hDEAD_BEEF, 3, 1'b0);
        load_hit(32'h44, 32'hDEAD_BEEF);
        store(32'h200, 32'h1234_5678, 0, 1'b0);
        load_miss(32'h200, 32'h1234_5678);
        store(32'h48, 32'hCAFE_F00D, 0, 1'b1);
        load_hit(32'h48, 32'hCAFE_F00D);
        load_miss(32'h440, 32'h1000_0440);

        // Abandon a fill of 0x40 after two words have been accepted.
        addr = 32'h40; memread = 1'b1;
        @(negedge clk);
        check("mid_miss_stall", stall, 1);
        step();
        step();
        step();
        check("mid_fill_memread", mem_read, 1);
        reset = 1'b1; memread = 1'b0;
        #1;
        check("mid_rst_memread", mem_read, 0);
        check("mid_rst_stall", stall, 0);
        $display("reset during fill of %h", addr);
        step();
        reset = 1'b0;
        step();

        load_miss(32'h40, 32'h1000_0040);
        load_miss(32'h440, 32'h1000_0440);
        load_miss(32'h40, 32'h1000_0040);
`ifdef CACHE_STATS_EN
        check("miss_count", miss_count, 3);
        check("hit_count", hit_count, 0);
`endif
        load_hit(32'h44, 32'hDEAD_BEEF);
        load_hit(32'h48, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache.md
CACHE -- requirements
Module: cache

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter LINES, default 16, number of direct-mapped lines (power of 2, >=2).
REQ-004 SHALL have parameter LINE_WORDS, default 4, words per line (power of 2, >=1).
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port addr, input, ADDR_W, CPU byte address; bits [1:0] ignored.
REQ-008 SHALL have port wdata, input, WIDTH, CPU store data.
REQ-009 SHALL have port memread, input, 1, CPU load request.
REQ-010 SHALL have port memwrite, input, 1, CPU store request.
REQ-011 SHALL have port rdata, output, WIDTH, load data; valid when memread=1 and stall=0.
REQ-012 SHALL have port stall, output, 1, CPU must hold addr, wdata and request while high.
REQ-013 SHALL have ports mem_addr (output, ADDR_W), mem_wdata (output, WIDTH), mem_rdata (input, WIDTH), mem_read (output, 1), mem_write (output, 1), mem_ready (input, 1): backing-memory handshake.

Function
REQ-014 SHALL split addr into tag | index (log2 LINES) | word offset (log2 LINE_WORDS) | byte [1:0].
REQ-015 SHALL have FSM states IDLE, FILL, WRITE.
REQ-016 Read hit (IDLE, memread, valid and tag match): rdata combinational from line, stall=0, zero latency.
REQ-017 Read miss: stall=1 same cycle; next edge go to FILL with fill counter=0.
REQ-018 FILL: mem_read=1, mem_addr = {tag, index, counter, 2'b00}; each cycle with mem_ready=1 writes mem_rdata into word counter and increments counter.
REQ-019 FILL: on acceptance of word LINE_WORDS-1, set line valid and tag, return to IDLE; the held request then hits on the following cycle.
REQ-020 Write (IDLE, memwrite): write-through, no-write-allocate; on tag hit update cached word at the transition edge; go to WRITE; stall=1.
REQ-021 WRITE: mem_write=1, mem_addr=addr, mem_wdata=wdata held until mem_ready=1; on that edge return to IDLE with stall=0 in that same cycle (combinational from mem_ready).
REQ-022 memread and memwrite both high SHALL be treated as write only.
REQ-023 mem_read and mem_write SHALL never be high together; both low in IDLE.
REQ-024 Write miss SHALL leave all valid bits and tags unchanged.
REQ-025 No request in IDLE: stall=0, no state change.

Reset
REQ-026 reset high SHALL immediately force state IDLE, clear all valid bits, fill counter 0, mem_read=0, mem_write=0, stall=0 (with no request pending).
REQ-027 Reset mid-FILL or mid-WRITE SHALL abandon the transaction; the partially filled line remains invalid.
REQ-028 Data array contents need not be reset.

Configuration
REQ-029 Macro CACHE_STATS_EN defined: SHALL add outputs hit_count and miss_count (32 bits each, reset 0, saturating at all-ones); each read access counts once, either as hit or as miss, when first detected in IDLE; writes are not counted.
REQ-030 Macro undefined: SHALL omit those ports and counters; other behaviour identical.

Structure
REQ-031 Package cache_pkg SHALL hold the FSM state type and functions deriving offset/index/tag widths from the parameters.
REQ-032 Sub-module cache_tagram SHALL hold the valid and tag arrays: async read, sync write, async clear on reset.

Verification
REQ-033 After reset, load 0x40 -> miss, stall high; 4 reads at 0x40,0x44,0x48,0x4C with mem_ready every cycle; rdata = mem word 0x40 with stall low one cycle later.
REQ-034 Load 0x48 after the 0x40 fill -> hit, stall=0 same cycle, no mem_read.
REQ-035 Store 0xDEADBEEF to 0x44 (line cached) with mem_ready delayed 3 cycles -> stall 4 cycles, mem_write held; later load 0x44 hits returning 0xDEADBEEF.
REQ-036 Store to uncached 0x200 -> mem_write issued; subsequent load 0x200 misses.
REQ-037 Assert reset after 2nd fill word -> mem_read drops immediately; reload of 0x40 misses.
REQ-038 Loads 0x40, 0x440 (same index, LINES=16, LINE_WORDS=4), 0x40 -> three misses; with CACHE_STATS_EN, miss_count=3, hit_count=0.
